fp_addsub_align_stage: RTL
==========================

Name: fp_addsub_align_stage

Overview:
- Two-stage pipelined alignment stage of the FP add/sub datapath. Sits directly downstream of the pre-align stage and consumes its unpacked sign, exponent, 25-bit mantissa and InputExc fields.
- Stage 1 orders the operands by magnitude. Stage 2 right-shifts the smaller mantissa by the exponent difference and computes a sticky bit.
- Uses a valid/ready handshake on both sides so the downstream adder can stall the pipeline.

Parameters:
- EW, 8, exponent width
- MW, 25, mantissa width (hidden bit + 23 fraction + 1 guard)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream operand pair valid
- in_ready  out  1  stage can accept this cycle
- Opr  in  1  0=add, 1=subtract
- Sa  in  1  sign of A
- Sb  in  1  sign of B
- Ea  in  EW  exponent of A
- Eb  in  EW  exponent of B
- Ma  in  MW  mantissa of A
- Mb  in  MW  mantissa of B
- InputExc  in  7  exception vector from pre-align
- out_valid  out  1  aligned result valid
- out_ready  in  1  downstream accepts
- Emax  out  EW  larger exponent
- Mmax  out  MW  mantissa of the larger operand, unshifted
- Mmin  out  MW  mantissa of the smaller operand, right-shifted
- Sticky  out  1  OR of bits shifted out of Mmin
- Sout  out  1  provisional result sign
- OpEff  out  1  effective operation (1 = subtract magnitudes)
- Swapped  out  1  B was the larger operand
- ExcOut  out  7  InputExc, delayed in step with the data

Behaviour:
- Reset (asynchronous, rst_n=0):
  - v1 and v2 cleared.
  - All data registers and outputs cleared to 0.
  - in_ready=1 from the first edge after rst_n rises.
- Handshake:
  - adv2 = ~v2 | out_ready
  - adv1 = ~v1 | adv2
  - in_ready = adv1 (combinational)
  - out_valid = v2
- Transfers:
  - Input transfer on in_valid & in_ready.
  - Output transfer on out_valid & out_ready.
  - While out_valid & ~out_ready, all outputs are held stable.
- Stage 1 (loads on adv1):
  - v1 <= in_valid.
  - Swap = (Eb > Ea) | ((Ea == Eb) & (Mb > Ma)), unsigned compare.
  - Registers larger/smaller exponent and mantissa, and d = Elarge − Esmall (EW bits, never negative).
  - OpEff = Opr ^ Sa ^ Sb.
  - Sout = Swap ? (Sb ^ Opr) : Sa.
  - Registers InputExc and Swap.
- Stage 2 (loads on adv2):
  - v2 <= v1.
  - Mmin = Msmall >> d. When d >= MW, Mmin = 0.
  - Sticky = OR of Msmall bits below position d. When d >= MW, Sticky = |Msmall.
  - Passes through Emax, Mmax, Sout, OpEff, Swapped, ExcOut.
- Latency and throughput:
  - Latency is exactly 2 cycles from input transfer to out_valid when out_ready stays high.
  - Throughput is 1 per cycle.
- Bubbles: if in_valid=0 during an advance, the stage's valid clears. Data registers may update but are don't-care.
- Simultaneous events: input transfer and output transfer in the same cycle with both stages full is legal. Nothing is lost or duplicated.
- Exceptions: the datapath is not gated on ExcOut. Downstream handles exceptions.
- Equal operands: A=B gives Swapped=0, d=0, Mmin=Ma, Sticky=0.
- Reset mid-operation: any in-flight entries are discarded, with no output transfer for them.

Optional Feature:
- Macro: FPADDSUB_ALIGN_STICKY_EN.
- Defined: Sticky is computed as described above.
- Undefined: no sticky logic is built, Sticky is tied to 0, and shifted-out bits are dropped.

Test Plan:
- 1.0 + 2.0 (Ea=127, Ma=0x1000000; Eb=128, Mb=0x1000000; Opr=0), out_ready=1 -> after 2 cycles: Swapped=1, Emax=128, Mmax=0x1000000, Mmin=0x0800000, Sticky=0, OpEff=0, Sout=0.
- Ea=130, Eb=127, Mb=0x1000007, Sa=0, Sb=1, Opr=0 -> Mmin=0x0200000, OpEff=1, Sout=0, Swapped=0. Sticky=1 with FPADDSUB_ALIGN_STICKY_EN, Sticky=0 without it.
- Ea=150, Eb=100, Mb=0x1000001 (d=50) -> Mmin=0, Sticky=1 (with EN), Emax=150.
- Ea=Eb=127, Ma=0x1000000, Mb=0x1800000, Sa=0, Sb=0, Opr=1 -> Swapped=1, Mmax=0x1800000, Mmin=0x1000000, Sout=1.
- Stream 4 back-to-back inputs with out_ready=0 for 5 cycles -> 2 accepted, in_ready=0 from the 3rd attempt, outputs held stable. After release all 4 emerge in order with no duplicates.
- Pulse rst_n low with 2 entries in flight -> out_valid=0 immediately (asynchronously), in_ready=1 after release, no stale outputs appear.

Source files
------------

// File: rtl/fp_addsub_align_stage_if.sv
// Purpose: operand/result bundle for the FP add/sub alignment stage (both handshake sides).
// Latency: n/a (wiring only).
// Backpressure: carries in_valid/in_ready upstream and out_valid/out_ready downstream.
//
// Modports:
//   slave  - the alignment stage's view (consumes operands, produces aligned result)
//   master - the surrounding environment's view (pre-align stage + adder)
interface fp_addsub_align_stage_if #(
    parameter int EW = 8,
    parameter int MW = 25
) ();
    // upstream side
    logic          in_valid;
    logic          in_ready;
    logic          Opr;
    logic          Sa;
    logic          Sb;
    logic [EW-1:0] Ea;
    logic [EW-1:0] Eb;
    logic [MW-1:0] Ma;
    logic [MW-1:0] Mb;
    logic [6:0]    InputExc;
    // downstream side
    logic          out_valid;
    logic          out_ready;
    logic [EW-1:0] Emax;
    logic [MW-1:0] Mmax;
    logic [MW-1:0] Mmin;
    logic          Sticky;
    logic          Sout;
    logic          OpEff;
    logic          Swapped;
    logic [6:0]    ExcOut;

    modport slave (
        input  in_valid, Opr, Sa, Sb, Ea, Eb, Ma, Mb, InputExc, out_ready,
        output in_ready, out_valid, Emax, Mmax, Mmin, Sticky, Sout, OpEff, Swapped, ExcOut
    );

    modport master (
        output in_valid, Opr, Sa, Sb, Ea, Eb, Ma, Mb, InputExc, out_ready,
        input  in_ready, out_valid, Emax, Mmax, Mmin, Sticky, Sout, OpEff, Swapped, ExcOut
    );
endinterface

// File: rtl/fp_addsub_align_stage.sv
// Purpose: FP add/sub alignment - stage 1 orders operands by magnitude, stage 2 right-shifts the smaller mantissa.
// Latency: 2 cycles from input transfer to out_valid, 1 result per cycle.
// Backpressure: valid/ready; a stalled output holds both stages, in_ready drops only when both are full.
//
// Ports: clk (rising edge), rst_n (async active-low), io (fp_addsub_align_stage_if.slave):
//   in:  in_valid, Opr, Sa, Sb, Ea, Eb, Ma, Mb, InputExc, out_ready
//   out: in_ready, out_valid, Emax, Mmax, Mmin, Sticky, Sout, OpEff, Swapped, ExcOut
// Build option: define FPADDSUB_ALIGN_STICKY_EN to build the sticky logic; otherwise Sticky is tied to 0.
module fp_addsub_align_stage #(
    parameter int EW = 8,
    parameter int MW = 25
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fp_addsub_align_stage_if.slave  io
);

    // ---------------- handshake ----------------
    logic v1_q, v2_q;
    logic adv1, adv2;

    assign adv2        = ~v2_q | io.out_ready;
    assign adv1        = ~v1_q | adv2;
    assign io.in_ready = adv1;
    assign io.out_valid = v2_q;

    // ---------------- stage 1: magnitude ordering ----------------
    logic          swap_d;
    logic [EW-1:0] elarge_d, esmall_d, d_d;
    logic [MW-1:0] mlarge_d, msmall_d;
    logic          opeff_d, sout_d;

    logic [EW-1:0] elarge1_q, d1_q;
    logic [MW-1:0] mlarge1_q, msmall1_q;
    logic          swap1_q, opeff1_q, sout1_q;
    logic [6:0]    exc1_q;

    always_comb begin
        // Equal exponents fall back to the mantissa compare; full equality keeps A as larger.
        swap_d   = (io.Eb > io.Ea) | ((io.Ea == io.Eb) & (io.Mb > io.Ma));
        elarge_d = swap_d ? io.Eb : io.Ea;
        esmall_d = swap_d ? io.Ea : io.Eb;
        mlarge_d = swap_d ? io.Mb : io.Ma;
        msmall_d = swap_d ? io.Ma : io.Mb;
        d_d      = elarge_d - esmall_d;   // ordering guarantees this never wraps
        opeff_d  = io.Opr ^ io.Sa ^ io.Sb;
        // When B dominates, the result takes B's sign as seen through the operation.
        sout_d   = swap_d ? (io.Sb ^ io.Opr) : io.Sa;
    end

    // ---------------- stage 2: alignment shift ----------------
    logic [MW-1:0] mmin_d;
    logic          sticky_d;

    // A shift amount of MW or more empties the vector, which gives Mmin = 0 without a special case.
    assign mmin_d = msmall1_q >> d1_q;

`ifdef FPADDSUB_ALIGN_STICKY_EN
    logic [MW-1:0] ones_w, lost_mask_w;
    assign ones_w      = {MW{1'b1}};
    // Mask of bit positions below d; saturates to all ones once d >= MW.
    assign lost_mask_w = ~(ones_w << d1_q);
    assign sticky_d    = |(msmall1_q & lost_mask_w);
`else
    assign sticky_d    = 1'b0;
`endif

    logic [EW-1:0] emax2_q;
    logic [MW-1:0] mmax2_q, mmin2_q;
    logic          sticky2_q, sout2_q, opeff2_q, swap2_q;
    logic [6:0]    exc2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            elarge1_q <= '0;
            d1_q      <= '0;
            mlarge1_q <= '0;
            msmall1_q <= '0;
            swap1_q   <= 1'b0;
            opeff1_q  <= 1'b0;
            sout1_q   <= 1'b0;
            exc1_q    <= '0;
        end else if (adv1) begin
            v1_q <= io.in_valid;
            // Data only moves for real operands; bubbles leave the old (don't-care) contents.
            if (io.in_valid) begin
                elarge1_q <= elarge_d;
                d1_q      <= d_d;
                mlarge1_q <= mlarge_d;
                msmall1_q <= msmall_d;
                swap1_q   <= swap_d;
                opeff1_q  <= opeff_d;
                sout1_q   <= sout_d;
                exc1_q    <= io.InputExc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q      <= 1'b0;
            emax2_q   <= '0;
            mmax2_q   <= '0;
            mmin2_q   <= '0;
            sticky2_q <= 1'b0;
            sout2_q   <= 1'b0;
            opeff2_q  <= 1'b0;
            swap2_q   <= 1'b0;
            exc2_q    <= '0;
        end else if (adv2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                emax2_q   <= elarge1_q;
                mmax2_q   <= mlarge1_q;
                mmin2_q   <= mmin_d;
                sticky2_q <= sticky_d;
                sout2_q   <= sout1_q;
                opeff2_q  <= opeff1_q;
                swap2_q   <= swap1_q;
                exc2_q    <= exc1_q;
            end
        end
    end

    assign io.Emax    = emax2_q;
    assign io.Mmax    = mmax2_q;
    assign io.Mmin    = mmin2_q;
    assign io.Sticky  = sticky2_q;
    assign io.Sout    = sout2_q;
    assign io.OpEff   = opeff2_q;
    assign io.Swapped = swap2_q;
    assign io.ExcOut  = exc2_q;

endmodule
